add_key: RTL and testbench
==========================

# add_key

Multi-cycle AES AddRoundKey engine: on a start request it XORs a 128-bit state block with a 128-bit round key and presents the result on `addkey` with a completion flag. It processes one lane per clock, most-significant lane first. It sits in the AES round datapath between the MixColumns/ShiftRows stages and the round-key source, and runs under a simple start/finish handshake.

## Interface
- `LANE_W`, default 32: lane width processed per cycle. Legal values are 8, 16, 32, 64 and 128; must divide 128.
- `clk`  in  1: single clock; all state is updated on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request; sampled on the rising edge of `clk`.
- `in`  in  128: state block; byte 0 is in bits [127:120].
- `key`  in  128: round key, same byte order as `in`.
- `finish`  out  1: level done flag.
- `addkey`  out  128: result register.

## Operation
- States are IDLE, RUN and DONE. Reset enters IDLE.
- Accepting a request (state IDLE or DONE, `start`=1 at an edge):
  - latch `in` and `key` into internal registers;
  - clear the result register to 0;
  - set the lane index to 0 and clear `finish`;
  - go to RUN.
- In RUN, each edge:
  - result lane[idx] = in_reg lane[idx] XOR key_reg lane[idx];
  - lane 0 is bits [127:128-LANE_W];
  - idx increments by 1.
- On the edge that writes the last lane (idx = 128/LANE_W - 1), go to DONE and set `finish`=1 on that same edge.
- In DONE:
  - `addkey` holds the full XOR result;
  - `finish` stays 1 until the next request is accepted.
- Input changes after acceptance have no effect, because operands are latched.
- `start` while in RUN is ignored; no queueing and no restart. A `start` held high over several cycles therefore produces exactly one operation.
- A request in DONE restarts immediately. `finish` drops on the accept edge, giving a fresh 0→1 edge per operation.
- Arithmetic is pure bitwise XOR, with no carries and no width growth.

## Timing
- Reset values:
  - `finish`=0;
  - `addkey`=0;
  - operand registers = 0;
  - idx = 0;
  - state IDLE.
- Latency: if a request is accepted at edge N, `finish` rises after edge N + 128/LANE_W. With the default of 32 this is 4 cycles.
- Throughput is one block per 128/LANE_W + 1 cycles when `start` is re-asserted in DONE.
- `addkey` during RUN is partial: completed lanes hold results and the rest are 0. It is valid only while `finish`=1.
- Reset asserted mid-RUN or in DONE clears every register immediately, independent of `clk`, and aborts the operation. After release the block is in IDLE and needs a new `start`.
- `finish` and `addkey` are registered outputs with no combinational path from the inputs.

## Structure
- Shared package `aes_pkg`:
  - `aes_block_t` (logic [127:0]);
  - the state enum `addkey_state_e` (IDLE, RUN, DONE);
  - constant `AES_BLOCK_W` = 128.
- One sub-module, `xor_lane` (parameter W): a combinational W-bit XOR of two lane operands. It is instantiated once and fed by lane-select muxes on the latched operands.
- Control FSM, lane counter (width clog2(128/LANE_W), minimum 1) and result write-enable decode live in the top.

## Test plan
All vectors use `key`=2b7e151628aed2a6abf7158809cf4f3c, `start` held 2 cycles, and LANE_W=32.
- Block 1: `in`=6bc1bee22e409f96e93d7e117393172a → `finish` rises 4 cycles after accept, `addkey`=40bfabf406ee4d3042ca6b997a5c5816.
- Back-to-back from DONE:
  - `in`=ae2d8a571e03ac9c9eb76fac45af8e51 → `finish` drops on the accept edge, then `addkey`=85539f4136ad7e3a35407a244c60c16d;
  - next `in`=30c81c46a35ce411e5fbc1191a0a52ef → 1bb609508bf236b74e0cd49113c51dd3.
- Operand latching:
  - `in`=f69f2445df4f9b17ad2b417be66c3710, then `in` and `key` changed to all-ones during RUN;
  - required result dde13153f7e149b106dc54f3efa3782c.
- Mid-operation reset: assert `rst` during lane 2 → `finish`=0 and `addkey`=0 immediately. With no `start` after release, the block stays idle for 10 cycles.
- Parameter sweep: repeat block 1 with LANE_W=8 and LANE_W=128 → same result, with `finish` latency 16 and 1 cycles respectively.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES block type, AddRoundKey FSM states and block width
package aes_pkg;
  localparam int AES_BLOCK_W = 128;
  typedef logic [AES_BLOCK_W-1:0] aes_block_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} addkey_state_e;
endpackage

// File: rtl/xor_lane.sv
// xor_lane: combinational W-bit XOR of two lane operands
module xor_lane #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_y
);
  assign o_y = i_a ^ i_b;
endmodule

// File: rtl/add_key.sv
// add_key: multi-cycle AES AddRoundKey, one lane per clock, MS lane first
module add_key import aes_pkg::*; #(
  parameter int LANE_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] in,
  input  logic [127:0] key,
  output logic         finish,
  output logic [127:0] addkey
);
  localparam int NL = AES_BLOCK_W / LANE_W;
  localparam int IW = NL > 1 ? $clog2(NL) : 1;
  addkey_state_e r_state;
  logic [IW-1:0] r_idx;
  aes_block_t r_in, r_key, r_res;
  logic r_fin;
  logic [7:0] w_pos;
  logic [LANE_W-1:0] w_a, w_b, w_x;
  logic w_acc, w_last;
  assign w_acc = start && r_state != RUN;
  assign w_last = r_idx == IW'(NL - 1);
  assign w_pos = 8'((NL - 1 - int'(r_idx)) * LANE_W);
  assign w_a = r_in[w_pos +: LANE_W];
  assign w_b = r_key[w_pos +: LANE_W];
  xor_lane #(.W(LANE_W)) u_xor (.i_a(w_a), .i_b(w_b), .o_y(w_x));
  assign finish = r_fin;
  assign addkey = r_res;
  // accept latches operands; RUN writes one lane per edge and flags DONE on the last
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_in <= '0;
      r_key <= '0;
      r_res <= '0;
      r_fin <= 1'b0;
    end else if (w_acc) begin
      r_state <= RUN;
      r_idx <= '0;
      r_in <= in;
      r_key <= key;
      r_res <= '0;
      r_fin <= 1'b0;
    end else if (r_state == RUN) begin
      r_res[w_pos +: LANE_W] <= w_x;
      r_idx <= w_last ? '0 : r_idx + 1'b1;
      r_state <= w_last ? DONE : RUN;
      r_fin <= w_last;
    end
endmodule

// File: tb/tb_add_key.sv
// tb_add_key: scoreboard bench for add_key at lane widths 32, 8 and 128
module tb_add_key;
  import aes_pkg::*;
  localparam aes_block_t K  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam aes_block_t B1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam aes_block_t E1 = 128'h40bfabf406ee4d3042ca6b997a5c5816;
  localparam aes_block_t B2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam aes_block_t E2 = 128'h85539f4136ad7e3a35407a244c60c16d;
  localparam aes_block_t B3 = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
  localparam aes_block_t E3 = 128'h1bb609508bf236b74e0cd49113c51dd3;
  localparam aes_block_t B4 = 128'hf69f2445df4f9b17ad2b417be66c3710;
  localparam aes_block_t E4 = 128'hdde13153f7e149b106dc54f3efa3782c;
  logic clk = 1'b0;
  logic rst, start;
  logic [127:0] in, key;
  logic fin32, fin8, fin128;
  logic [127:0] ak32, ak8, ak128;
  aes_block_t q[$];
  int n_chk = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  add_key #(.LANE_W(32)) d32 (.clk(clk), .rst(rst), .start(start), .in(in), .key(key), .finish(fin32), .addkey(ak32));
  add_key #(.LANE_W(8)) d8 (.clk(clk), .rst(rst), .start(start), .in(in), .key(key), .finish(fin8), .addkey(ak8));
  add_key #(.LANE_W(128)) d128 (.clk(clk), .rst(rst), .start(start), .in(in), .key(key), .finish(fin128), .addkey(ak128));
  task automatic chk(input string t, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", t, got, exp);
    end
  endtask
  task automatic op(input aes_block_t v, input aes_block_t e, input logic mess);
    int n;
    in = v;
    key = K;
    start = 1'b1;
    q.push_back(e);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        chk("accept_drop", {127'b0, fin32}, 0);
        if (mess) begin
          in = '1;
          key = '1;
        end
      end
      if (n == 2) start = 1'b0;
    end while (!fin32 && n < 40);
    start = 1'b0;
    chk("latency32", n - 1, 4);
    chk("result32", ak32, q.pop_front());
    @(posedge clk);
    #1;
    chk("hold_fin", {127'b0, fin32}, 1);
    chk("hold_res", ak32, e);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    int n, l8, l32, l128;
    rst = 1'b1;
    start = 1'b0;
    in = '0;
    key = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fin", {125'b0, fin32, fin8, fin128}, 0);
    chk("rst_ak32", ak32, 0);
    chk("rst_ak8", ak8 | ak128, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_fin", {127'b0, fin32}, 0);
    op(B1, E1, 1'b0);
    op(B2, E2, 1'b0);
    op(B3, E3, 1'b0);
    op(B4, E4, 1'b1);
    in = B1;
    key = K;
    start = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("partial", ak32, {E1[127:64], 64'b0});
    rst = 1'b1;
    #1;
    chk("async_fin", {127'b0, fin32}, 0);
    chk("async_ak", ak32, 0);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("stay_idle", {ak32[126:0], fin32}, 0);
    end
    in = B1;
    key = K;
    start = 1'b1;
    repeat (3) q.push_back(E1);
    l8 = -1;
    l32 = -1;
    l128 = -1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 2) start = 1'b0;
      if (fin8 && l8 < 0) l8 = n - 1;
      if (fin32 && l32 < 0) l32 = n - 1;
      if (fin128 && l128 < 0) l128 = n - 1;
    end while (l8 < 0 && n < 40);
    start = 1'b0;
    chk("sweep_lat8", l8, 16);
    chk("sweep_lat32", l32, 4);
    chk("sweep_lat128", l128, 1);
    chk("sweep_res8", ak8, q.pop_front());
    chk("sweep_res32", ak32, q.pop_front());
    chk("sweep_res128", ak128, q.pop_front());
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_chk, n_err);
    $finish;
  end
endmodule
